vga_pixel_fetch: RTL and testbench

Framebuffer fetch-and-serialize stage that sits directly downstream of the VGA sync generator. It consumes the generator's `load` / `next_addr` / `reset_addr` strobes, fetches 32-bit framebuffer words over a simple request/acknowledge memory port, and shifts them out as a 1-bpp pixel stream. Its outputs are the pixel, hsync and vsync, delayed so all three are mutually aligned for the DAC/pins.

---
 rtl/vga_pkg.sv | 15 +
 rtl/vga_word_shifter.sv | 42 ++++
 rtl/vga_pixel_fetch.sv | 151 +++++++++++++++
 tb/tb_vga_pixel_fetch.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and fetch FSM encoding for the VGA framebuffer fetch path.
package vga_pkg;

    localparam int WORD_W          = 32;
    localparam int PIX_PER_WORD    = 32;
    localparam int WORDS_PER_LINE  = 32;
    localparam int ACTIVE_LINES    = 768;
    localparam int WORDS_PER_FRAME = 24576;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/vga_word_shifter.sv
// 32-bit MSB-first pixel serializer with output gating by the delayed active flag.
module vga_word_shifter
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] word,
    input  logic              active,
    output logic              pixel
);

    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic              pix_q, pix_d;
    logic              active_q, active_d;

    // A load bypasses the shifter so the word's MSB appears on the very next cycle.
    always_comb begin
        pix_d    = shreg_q[WORD_W-1];
        shreg_d  = shreg_q << 1;
        active_d = active;
        if (load) begin
            pix_d   = word[WORD_W-1];
            shreg_d = word << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q  <= '0;
            pix_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            shreg_q  <= shreg_d;
            pix_q    <= pix_d;
            active_q <= active_d;
        end
    end

    assign pixel = pix_q & active_q;

endmodule

// File: rtl/vga_pixel_fetch.sv
// Framebuffer word fetch, one-word prefetch buffer and sync alignment for a 1-bpp VGA stream.
module vga_pixel_fetch
    import vga_pkg::*;
#(
    parameter int                ADDR_W    = 15,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              load,
    input  logic              next_addr,
    input  logic              reset_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_data,
    output logic              pixel,
    output logic              hsync,
    output logic              vsync,
    output logic              underrun
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_req_q, mem_req_d;
    logic              pending_q, pending_d;
    logic              discard_q, discard_d;
    logic              start_q;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic              buf_valid_q, buf_valid_d;
    logic              underrun_q, underrun_d;
    logic              hsync_q, vsync_q;

    logic              strobe;
    logic              ack_take;
    logic              load_en;
    logic [WORD_W-1:0] load_word;

    always_comb begin
        strobe     = next_addr | reset_addr;
        load_en    = load & active;
        ack_take   = 1'b0;
        addr_d     = addr_q;
        state_d    = state_q;
        pending_d  = pending_q;
        discard_d  = discard_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;

        if (reset_addr) begin
            addr_d = '0;
        end else if (next_addr) begin
            addr_d = addr_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                // start_q stands in for a reset_addr strobe on the first cycle out of reset.
                if (strobe || pending_q || start_q) begin
                    state_d    = ST_REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = BASE_ADDR + addr_d;
                    pending_d  = 1'b0;
                end
            end
            ST_REQ: begin
                if (strobe) begin
                    pending_d = 1'b1;
                end
                if (mem_ack) begin
                    // Data in flight when the address was rewound belongs to the old frame.
                    ack_take  = ~(discard_q | reset_addr);
                    discard_d = 1'b0;
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                end else if (reset_addr) begin
                    discard_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        underrun_d  = underrun_q;
        load_word   = buf_valid_q ? buf_q : '0;
        if (load_en) begin
            buf_valid_d = 1'b0;
            if (!buf_valid_q) begin
                underrun_d = 1'b1;
            end
        end
        // An accepted ack lands after the load has already taken the old word.
        if (ack_take) begin
            buf_d       = mem_data;
            buf_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            mem_addr_q  <= BASE_ADDR;
            mem_req_q   <= 1'b0;
            pending_q   <= 1'b0;
            discard_q   <= 1'b0;
            start_q     <= 1'b1;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_req_q   <= mem_req_d;
            pending_q   <= pending_d;
            discard_q   <= discard_d;
            start_q     <= 1'b0;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            underrun_q  <= underrun_d;
            hsync_q     <= hsync_in;
            vsync_q     <= vsync_in;
        end
    end

    vga_word_shifter u_shifter (
        .clk    (clk),
        .reset  (reset),
        .load   (load_en),
        .word   (load_word),
        .active (active),
        .pixel  (pixel)
    );

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed-plus-random bench for vga_pixel_fetch with a word-level reference model.
module tb_vga_pixel_fetch;

    localparam logic [14:0] BASE = 15'h0100;

    logic        clk;
    logic        reset;
    logic        active;
    logic        hsync_in;
    logic        vsync_in;
    logic        load;
    logic        next_addr;
    logic        reset_addr;
    logic        mem_req;
    logic [14:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic        pixel;
    logic        hsync;
    logic        vsync;
    logic        underrun;

    int          n_vec = 0;
    int          n_err = 0;
    int          mem_lat = 3;
    int          mem_mode = 0;
    int          req_age = 0;
    logic [31:0] mem_seed;
    logic        force_ack = 1'b0;
    logic        req_seen = 1'b0;

    // reference model state
    logic [14:0] m_addr;
    logic [31:0] m_buf;
    logic [31:0] m_word;
    logic        m_valid;
    logic        m_underrun;
    logic        m_disc;
    int          m_idx;
    logic        exp_pixel = 1'b0;
    logic        exp_h = 1'b1;
    logic        exp_v = 1'b1;

    vga_pixel_fetch #(
        .ADDR_W    (15),
        .BASE_ADDR (BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .active     (active),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .load       (load),
        .next_addr  (next_addr),
        .reset_addr (reset_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .pixel      (pixel),
        .hsync      (hsync),
        .vsync      (vsync),
        .underrun   (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [14:0] a);
        logic [31:0] r;
        case (mem_mode)
            0:       r = {17'd0, a};
            1:       r = mem_seed ^ ({17'd0, a} * 32'h9E37_79B1);
            default: r = 32'hA000_0001;
        endcase
        return r;
    endfunction

    // Memory responder: acks after mem_lat cycles of request, or immediately on force_ack.
    always begin
        @(posedge clk);
        #1;
        mem_ack  = 1'b0;
        mem_data = $urandom;
        if (force_ack) begin
            mem_ack  = 1'b1;
            mem_data = mem_req ? mem_word(mem_addr) : $urandom;
            req_age  = 0;
        end else if (mem_req && !reset) begin
            req_age++;
            if (req_age >= mem_lat) begin
                mem_ack  = 1'b1;
                mem_data = mem_word(mem_addr);
                req_age  = 0;
            end
        end else begin
            req_age = 0;
        end
    end

    // Word-level model: buffer contents, underrun, expected pixel bit and sync delay.
    always @(posedge clk) begin
        if (reset) begin
            m_addr     = '0;
            m_buf      = '0;
            m_word     = '0;
            m_valid    = 1'b0;
            m_underrun = 1'b0;
            m_disc     = 1'b0;
            m_idx      = 32;
            exp_pixel  = 1'b0;
            exp_h      = 1'b1;
            exp_v      = 1'b1;
        end else begin
            logic take;
            exp_h = hsync_in;
            exp_v = vsync_in;
            if (req_seen && reset_addr) m_disc = 1'b1;
            take = req_seen && mem_ack && !m_disc;
            if (req_seen && mem_ack) m_disc = 1'b0;
            if (load && active) begin
                if (m_valid) begin
                    m_word = m_buf;
                end else begin
                    m_word     = '0;
                    m_underrun = 1'b1;
                end
                m_valid = 1'b0;
                m_idx   = 0;
            end
            if (m_idx < 32) begin
                exp_pixel = active & m_word[31-m_idx];
                m_idx++;
            end else begin
                exp_pixel = 1'b0;
            end
            if (take) begin
                m_buf   = mem_data;
                m_valid = 1'b1;
            end
            if (reset_addr)     m_addr = '0;
            else if (next_addr) m_addr = m_addr + 15'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic        pr, pa, prst;
        logic [14:0] ea;
        pr       = mem_req;
        pa       = mem_ack;
        prst     = reset;
        req_seen = mem_req;
        hsync_in = 1'($urandom_range(0, 1));
        vsync_in = 1'($urandom_range(0, 1));
        @(posedge clk);
        #2;
        chk("pixel", 32'(pixel), 32'(exp_pixel));
        chk("hsync", 32'(hsync), 32'(exp_h));
        chk("vsync", 32'(vsync), 32'(exp_v));
        chk("underrun", 32'(underrun), 32'(m_underrun));
        if (!reset && !prst && pr && !pa) chk("req_hold", 32'(mem_req), 32'd1);
        if (!reset && !pr && mem_req) begin
            ea = BASE + m_addr;
            chk("req_addr", 32'(mem_addr), 32'(ea));
        end
    endtask

    task automatic wait_fill(input int max);
        int n;
        n = 0;
        while (mem_ack !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk("fill_timeout", 32'(n < max), 32'd1);
        tick();
    endtask

    task automatic load_collect(output logic [31:0] w);
        logic [31:0] t;
        active = 1'b1;
        load   = 1'b1;
        tick();
        load   = 1'b0;
        t[31]  = pixel;
        for (int k = 30; k >= 0; k--) begin
            tick();
            t[k] = pixel;
        end
        w = t;
    endtask

    task automatic strobe_rewind();
        reset_addr = 1'b1;
        tick();
        reset_addr = 1'b0;
    endtask

    task automatic run_line(input logic [14:0] start);
        logic [14:0] ea;
        for (int w = 0; w < 32; w++) begin
            mem_lat   = $urandom_range(1, 30);
            active    = 1'b1;
            load      = 1'b1;
            tick();
            load      = 1'b0;
            next_addr = 1'b1;
            tick();
            next_addr = 1'b0;
            ea = BASE + start + 15'(w + 1);
            chk("line_req", 32'(mem_req), 32'd1);
            chk("line_addr", 32'(mem_addr), 32'(ea));
            repeat (30) tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [14:0] ea;
        mem_seed   = $urandom;
        reset      = 1'b1;
        active     = 1'b0;
        hsync_in   = 1'b0;
        vsync_in   = 1'b0;
        load       = 1'b0;
        next_addr  = 1'b0;
        reset_addr = 1'b0;
        mem_ack    = 1'b0;
        mem_data   = '0;

        // 1: reset values, boot fetch, reset_addr refetch of word 0
        repeat (3) tick();
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'(BASE));
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_vsync", 32'(vsync), 32'd1);
        chk("rst_pixel", 32'(pixel), 32'd0);
        reset = 1'b0;
        tick();
        chk("boot_req", 32'(mem_req), 32'd1);
        chk("boot_addr", 32'(mem_addr), 32'(BASE));
        wait_fill(10);
        tick();
        strobe_rewind();
        chk("t1_req", 32'(mem_req), 32'd1);
        chk("t1_addr", 32'(mem_addr), 32'(BASE));
        wait_fill(10);

        // 2: fixed word serialized MSB first
        mem_mode = 2;
        strobe_rewind();
        wait_fill(10);
        load_collect(w);
        chk("t2_pixels", w, 32'hA000_0001);
        active = 1'b0;
        repeat (3) tick();

        // 3: full line, data = address
        mem_mode = 0;
        mem_lat  = 3;
        strobe_rewind();
        wait_fill(10);
        run_line(15'd0);
        chk("t3_no_underrun", 32'(underrun), 32'd0);
        load_collect(w);
        ea = BASE + 15'd32;
        chk("t3_word32", w, 32'(ea));

        // random-data line
        mem_mode = 1;
        mem_lat  = 3;
        strobe_rewind();
        wait_fill(10);
        run_line(15'd0);
        chk("rand_no_underrun", 32'(underrun), 32'd0);

        // 4: slow memory causes underrun
        mem_lat = 40;
        strobe_rewind();
        wait_fill(60);
        active    = 1'b1;
        load      = 1'b1;
        tick();
        load      = 1'b0;
        next_addr = 1'b1;
        tick();
        next_addr = 1'b0;
        repeat (29) tick();
        load_collect(w);
        chk("t4_word", w, 32'd0);
        chk("t4_underrun", 32'(underrun), 32'd1);
        repeat (10) tick();
        chk("t4_sticky", 32'(underrun), 32'd1);

        // 5: reset_addr while fetching word 17
        mem_mode = 0;
        mem_lat  = 3;
        active   = 1'b0;
        strobe_rewind();
        wait_fill(10);
        for (int i = 0; i < 16; i++) begin
            next_addr = 1'b1;
            tick();
            next_addr = 1'b0;
            wait_fill(10);
        end
        mem_lat   = 20;
        next_addr = 1'b1;
        tick();
        next_addr = 1'b0;
        ea = BASE + 15'd17;
        chk("t5_req17", 32'(mem_addr), 32'(ea));
        repeat (3) tick();
        strobe_rewind();
        wait_fill(30);
        mem_lat = 3;
        begin
            int n;
            n = 0;
            while (mem_req !== 1'b1 && n < 5) begin
                tick();
                n++;
            end
        end
        chk("t5_rereq", 32'(mem_req), 32'd1);
        chk("t5_rereq_addr", 32'(mem_addr), 32'(BASE));
        wait_fill(10);
        load_collect(w);
        chk("t5_word0", w, 32'(BASE));

        // 6: ignored inactive load; load and ack in the same cycle
        active = 1'b0;
        strobe_rewind();
        wait_fill(10);
        mem_lat = 1000;
        load    = 1'b1;
        tick();
        load    = 1'b0;
        next_addr = 1'b1;
        tick();
        next_addr = 1'b0;
        mem_mode  = 1;
        repeat (3) tick();
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        load_collect(w);
        chk("t6_old_buf", w, 32'(BASE));
        load_collect(w);
        ea = BASE + 15'd1;
        chk("t6_new_buf", w, mem_word(ea));

        // 7: reset mid-fetch, then a stray ack in IDLE
        mem_lat = 10;
        strobe_rewind();
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
        chk("t7_rst_req", 32'(mem_req), 32'd0);
        chk("t7_rst_underrun", 32'(underrun), 32'd0);
        reset   = 1'b0;
        mem_lat = 3;
        tick();
        wait_fill(10);
        repeat (2) tick();
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        tick();
        load_collect(w);
        chk("t7_late_ack", w, mem_word(BASE));
        active = 1'b0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
